wb_timer_irq: RTL

Wishbone-attached programmable interval timer: the interrupt source that drives the SoC's external interrupt input in the Verilator simulation top and on hardware. It counts clock ticks up to a software-set compare value, raises a level interrupt, and supports one-shot or auto-reload operation. Registers are accessed through a classic, single-beat Wishbone slave port. The interrupt pending bit is cleared by a write-1-to-clear.

---
 rtl/wb_timer_irq.sv | 82 ++++++++
 1 files changed

// File: rtl/wb_timer_irq.sv
// wb_timer_irq: Wishbone programmable interval timer with level interrupt.
// Optional 16-bit prescaler at 0x10 is built when WB_TIMER_PRESCALER_EN is defined.
module wb_timer_irq #(
  parameter int unsigned WIDTH = 32,
  parameter logic [31:0] RESET_COMPARE = 32'h60
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);
  logic en, reload, ie, pending, tick, hit, req, wr;
  logic [2:0] sel;
  logic [WIDTH-1:0] count, compare, wdat;
  logic [31:0] rdata, prescale_rd;
  logic unused_ok;
  assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = req & wb_we_i;
  assign sel = wb_adr_i[4:2];
  assign wdat = wb_dat_i[WIDTH-1:0];
  assign hit = tick & (count == compare);
  assign irq_o = pending & ie;
  assign unused_ok = ^{wb_adr_i[7:5], wb_adr_i[1:0], wb_dat_i};
`ifdef WB_TIMER_PRESCALER_EN
  logic [15:0] prescale, ps_cnt;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prescale <= '0;
      ps_cnt <= '0;
    end else begin
      if (wr && sel == 3'd4) prescale <= wb_dat_i[15:0];
      ps_cnt <= (!en || (wr && sel == 3'd4) || ps_cnt == prescale) ? '0 : ps_cnt + 16'd1;
    end
  end
  assign tick = en & (ps_cnt == prescale);
  assign prescale_rd = {16'd0, prescale};
`else
  assign tick = en;
  assign prescale_rd = '0;
`endif
  always_comb begin
    rdata = sel == 3'd0 ? {29'd0, ie, reload, en} :
            sel == 3'd1 ? 32'(count) :
            sel == 3'd2 ? 32'(compare) :
            sel == 3'd3 ? {31'd0, pending} :
            sel == 3'd4 ? prescale_rd : 32'd0;
  end
  // software writes to CTRL/COUNT override the tick's effect in the same cycle
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      en <= 1'b0;
      reload <= 1'b0;
      ie <= 1'b0;
      count <= '0;
      compare <= RESET_COMPARE[WIDTH-1:0];
      pending <= 1'b0;
    end else begin
      if (wr && sel == 3'd0) {ie, reload, en} <= wb_dat_i[2:0];
      else if (hit && !reload) en <= 1'b0;
      if (wr && sel == 3'd1) count <= wdat;
      else if (tick) count <= hit ? (reload ? '0 : count) : count + WIDTH'(1);
      if (wr && sel == 3'd2) compare <= wdat;
      if (hit) pending <= 1'b1;
      else if (wr && sel == 3'd3 && wb_dat_i[0]) pending <= 1'b0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rdata;
    end
  end
endmodule
